xor_share_arbiter: RTL

Shares one W-bit XOR datapath among N requesters. Each requester presents an operand pair through a valid/ready handshake. The arbiter grants one requester per cycle, computes A ^ B in the shared unit, and holds the result, tagged with the requester index, in a single-entry output register with downstream backpressure. It sits between the operand-producing blocks and any consumer of XOR results.

---
 rtl/xor_share_arbiter_if.sv | 26 ++
 rtl/xor_share_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/xor_share_arbiter_if.sv
// Handshake bundle between N operand requesters, the shared XOR arbiter and the result consumer.
// The arbiter uses the slave modport; the requester/consumer side uses master.
interface xor_share_arbiter_if #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = $clog2(N)
) ();
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic [W-1:0]   res_data;
  logic [IDW-1:0] res_id;
  logic           res_ready;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/xor_share_arbiter.sv
// N requesters share one W-bit XOR unit; the result sits in a 1-entry tagged register (1-cycle latency).
// Grants stall while the result is held and res_ready is low. `XOR_ARB_RR_EN picks round-robin, else fixed priority.
module xor_share_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  xor_share_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic           can_accept;
  logic           grant_vld;
  logic           xfer;
  logic [IDW-1:0] grant_idx;
  logic [W-1:0]   xor_res;

`ifdef XOR_ARB_RR_EN
  localparam logic [IDW:0] N_W = (IDW+1)'(N);
  logic [IDW-1:0] last_q, last_d;
  logic [IDW:0]   cand;

  // Search starts just past the last winner and wraps modulo N.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + (IDW+1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (!grant_vld && bus.req_valid[cand[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  assign last_d = xfer ? grant_idx : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IDW'(N - 1);
    else        last_q <= last_d;
  end
`else
  logic [IDW-1:0] k_idx;

  // Walk from the top down so the lowest asserted index is the last to overwrite.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    k_idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      k_idx = IDW'(k);
      if (bus.req_valid[k_idx]) begin
        grant_vld = 1'b1;
        grant_idx = k_idx;
      end
    end
  end
`endif

  always_comb begin
    xor_res = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IDW'(i)) xor_res = bus.req_a[i*W +: W] ^ bus.req_b[i*W +: W];
    end
  end

  assign can_accept = (state_q == EMPTY) || bus.res_ready;
  assign xfer       = can_accept && grant_vld;

  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    if (xfer) begin
      res_data_d = xor_res;
      res_id_d   = grant_idx;
    end
    case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (bus.res_ready && !xfer) state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  assign bus.req_ready = xfer ? (N'(1) << grant_idx) : '0;
  assign bus.res_valid = (state_q == FULL);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
endmodule
